// File: rtl/axi_stream_fifo_if.sv
// axi_stream_fifo_if: valid/ready stream bundle for axi_stream_fifo.
//  master : upstream producer + downstream consumer side (drives flush, beats in, rdy_out)
//  slave  : the FIFO itself (drives rdy_in, beats out, level and threshold flags)
//  Signals: flush, vld_in/rdy_in/data_in/last_in, vld_out/rdy_out/data_out/last_out,
//           level, almost_full, almost_empty.
interface axi_stream_fifo_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 6
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             flush;
  logic             vld_in;
  logic             rdy_in;
  logic [WIDTH-1:0] data_in;
  logic             last_in;
  logic             vld_out;
  logic             rdy_out;
  logic [WIDTH-1:0] data_out;
  logic             last_out;
  logic [LW-1:0]    level;
  logic             almost_full;
  logic             almost_empty;

  modport master (
    output flush, vld_in, data_in, last_in, rdy_out,
    input  rdy_in, vld_out, data_out, last_out, level, almost_full, almost_empty
  );

  modport slave (
    input  flush, vld_in, data_in, last_in, rdy_out,
    output rdy_in, vld_out, data_out, last_out, level, almost_full, almost_empty
  );
endinterface

// File: rtl/axi_stream_fifo.sv
// axi_stream_fifo: valid/ready stream FIFO for the rasterizer pipeline.
//  Any DEPTH >= 2 (pointers wrap by compare, no power-of-two rounding), registered
//  occupancy, almost_full/almost_empty flags, synchronous flush, and an optional
//  packet mode that withholds vld_out until a whole packet (or a full FIFO) is held.
// Ports:
//  clk    in  rising-edge clock
//  rst_n  in  synchronous active-low reset
//  s      slave modport of axi_stream_fifo_if (stream in/out, flush, level, flags)
module axi_stream_fifo #(
  parameter int WIDTH         = 64,
  parameter int DEPTH         = 6,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter bit PACKET_MODE   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_stream_fifo_if.slave   s
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] L_AF    = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] L_AE    = LW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

  if (WIDTH < 1)                                  begin : g_bad_width  $error("axi_stream_fifo: WIDTH must be >= 1");  end
  if (DEPTH < 2)                                  begin : g_bad_depth  $error("axi_stream_fifo: DEPTH must be >= 2");  end
  if (AFULL_THRESH > DEPTH || AFULL_THRESH < 0)   begin : g_bad_afull  $error("axi_stream_fifo: AFULL_THRESH out of range"); end
  if (AEMPTY_THRESH > DEPTH || AEMPTY_THRESH < 0) begin : g_bad_aempty $error("axi_stream_fifo: AEMPTY_THRESH out of range"); end
  if ($bits(s.data_in) != WIDTH)                  begin : g_bad_if     $error("axi_stream_fifo: interface WIDTH mismatch"); end

  // Bit WIDTH of each entry holds the beat's last flag.
  logic [WIDTH:0]  r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level, r_pkt_cnt;

  logic            w_full, w_avail, w_rdy_in, w_vld_out;
  logic            w_push, w_pop, w_push_last, w_pop_last;
  logic [WIDTH:0]  w_head;

  assign w_full   = (r_level == L_DEPTH);
  assign w_head   = r_mem[r_rd_ptr];

  // No bypass: a full FIFO refuses a push even while popping.
  assign w_rdy_in = rst_n & ~s.flush & ~w_full;

  // Packet mode releases data once a last beat is stored; the full term lets an
  // oversize packet cut through instead of deadlocking.
  if (PACKET_MODE) begin : g_pkt
    assign w_avail = (r_pkt_cnt != '0) | w_full;
  end else begin : g_stream
    assign w_avail = (r_level != '0);
  end

  assign w_vld_out   = rst_n & ~s.flush & w_avail;
  assign w_push      = s.vld_in & w_rdy_in;
  assign w_pop       = w_vld_out & s.rdy_out;
  assign w_push_last = w_push & s.last_in;
  assign w_pop_last  = w_pop & w_head[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n || s.flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + 1'b1;

      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;

      if (w_push_last && !w_pop_last)      r_pkt_cnt <= r_pkt_cnt + 1'b1;
      else if (!w_push_last && w_pop_last) r_pkt_cnt <= r_pkt_cnt - 1'b1;
    end
  end

  // Storage is not reset; w_push is already gated by reset and flush.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s.last_in, s.data_in};
  end

  assign s.rdy_in       = w_rdy_in;
  assign s.vld_out      = w_vld_out;
  assign s.data_out     = w_vld_out ? w_head[WIDTH-1:0] : '0;
  assign s.last_out     = w_vld_out & w_head[WIDTH];
  assign s.level        = r_level;
  assign s.almost_full  = (r_level >= L_AF);
  assign s.almost_empty = (r_level <= L_AE);
endmodule

// File: tb/tb_axi_stream_fifo.sv
// tb_axi_stream_fifo: drives a streaming (PACKET_MODE=0, index 0) and a packet-mode
// (PACKET_MODE=1, index 1) FIFO from the same inputs. Directed scenarios check
// fixed expected values; the random scenario checks against an array-based
// occupancy model of each FIFO.
module tb_axi_stream_fifo;
  localparam int W  = 16;
  localparam int D  = 6;
  localparam int LW = $clog2(D + 1);
  localparam int AF = D - 1;
  localparam int AE = 1;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic         vld_in = 1'b0, last_in = 1'b0, rdy_out = 1'b0;
  logic [W-1:0] data_in = '0;

  always #5 clk = ~clk;

  axi_stream_fifo_if #(.WIDTH(W), .DEPTH(D)) if0 ();
  axi_stream_fifo_if #(.WIDTH(W), .DEPTH(D)) if1 ();

  assign if0.flush = flush;  assign if0.vld_in = vld_in;  assign if0.data_in = data_in;
  assign if0.last_in = last_in;  assign if0.rdy_out = rdy_out;
  assign if1.flush = flush;  assign if1.vld_in = vld_in;  assign if1.data_in = data_in;
  assign if1.last_in = last_in;  assign if1.rdy_out = rdy_out;

  axi_stream_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .PACKET_MODE(1'b0))
    u_stream (.clk(clk), .rst_n(rst_n), .s(if0));
  axi_stream_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .PACKET_MODE(1'b1))
    u_packet (.clk(clk), .rst_n(rst_n), .s(if1));

  logic          o_vld [2], o_rdy [2], o_last [2], o_af [2], o_ae [2];
  logic [W-1:0]  o_data [2];
  logic [LW-1:0] o_lvl [2];

  assign o_vld[0] = if0.vld_out;  assign o_rdy[0] = if0.rdy_in;  assign o_last[0] = if0.last_out;
  assign o_af[0]  = if0.almost_full;  assign o_ae[0] = if0.almost_empty;
  assign o_data[0] = if0.data_out;  assign o_lvl[0] = if0.level;
  assign o_vld[1] = if1.vld_out;  assign o_rdy[1] = if1.rdy_in;  assign o_last[1] = if1.last_out;
  assign o_af[1]  = if1.almost_full;  assign o_ae[1] = if1.almost_empty;
  assign o_data[1] = if1.data_out;  assign o_lvl[1] = if1.level;

  // Reference model: ordered contents {last, data} and a count per FIFO.
  logic [W:0] mq [2][D];
  int         mcnt [2];
  int         total = 0, bad = 0;

  function automatic bit m_vld(int m);
    if (!rst_n || flush) return 1'b0;
    if (m == 0) return mcnt[m] != 0;
    if (mcnt[m] == D) return 1'b1;
    for (int i = 0; i < mcnt[m]; i++) if (mq[m][i][W]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_rdy(int m);
    return rst_n && !flush && (mcnt[m] != D);
  endfunction

  function automatic logic [W-1:0] m_data(int m);
    return m_vld(m) ? mq[m][0][W-1:0] : '0;
  endfunction

  function automatic bit m_last(int m);
    return m_vld(m) ? mq[m][0][W] : 1'b0;
  endfunction

  // One clock: decide handshakes from current inputs, advance the model, return at negedge.
  task automatic step();
    bit psh [2], pp [2];
    for (int m = 0; m < 2; m++) begin
      psh[m] = vld_in && m_rdy(m);
      pp[m]  = rdy_out && m_vld(m);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n || flush) mcnt[m] = 0;
      else begin
        if (pp[m]) begin
          for (int i = 0; i < D - 1; i++) mq[m][i] = mq[m][i+1];
          mcnt[m]--;
        end
        if (psh[m]) begin
          mq[m][mcnt[m]] = {last_in, data_in};
          mcnt[m]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; vld_in = 1'b0; rdy_out = 1'b0; last_in = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; vld_in = 1'b1; rdy_out = 1'b1; last_in = 1'b0;
    step(); step();
    #1;
    for (int m = 0; m < 2; m++) begin
      total++; if (o_rdy[m] !== 1'b0)  begin bad++; $display("FAIL reset_rdy_in[%0d] got=%b exp=0", m, o_rdy[m]); end
      total++; if (o_vld[m] !== 1'b0)  begin bad++; $display("FAIL reset_vld_out[%0d] got=%b exp=0", m, o_vld[m]); end
      total++; if (o_data[m] !== '0)   begin bad++; $display("FAIL reset_data[%0d] got=%h exp=0", m, o_data[m]); end
      total++; if (o_last[m] !== 1'b0) begin bad++; $display("FAIL reset_last[%0d] got=%b exp=0", m, o_last[m]); end
      total++; if (o_lvl[m] !== '0)    begin bad++; $display("FAIL reset_level[%0d] got=%0d exp=0", m, o_lvl[m]); end
      total++; if (o_ae[m] !== 1'b1)   begin bad++; $display("FAIL reset_aempty[%0d] got=%b exp=1", m, o_ae[m]); end
      total++; if (o_af[m] !== 1'b0)   begin bad++; $display("FAIL reset_afull[%0d] got=%b exp=0", m, o_af[m]); end
    end
    vld_in = 1'b0; rdy_out = 1'b0; rst_n = 1'b1;
    #1;
    total++; if (o_rdy[0] !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%b exp=1", o_rdy[0]); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    vld_in = 1'b1; rdy_out = 1'b0; last_in = 1'b0;
    for (int i = 0; i < D; i++) begin
      data_in = W'(i);
      step();
      total++; if (o_lvl[0] !== LW'(i + 1)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", o_lvl[0], i + 1); end
      total++; if (o_af[0] !== (i + 1 >= 5)) begin bad++; $display("FAIL fill_afull lvl=%0d got=%b exp=%b", i + 1, o_af[0], (i + 1 >= 5)); end
    end
    #1;
    total++; if (o_rdy[0] !== 1'b0) begin bad++; $display("FAIL full_rdy_in got=%b exp=0", o_rdy[0]); end
    vld_in = 1'b0; rdy_out = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      total++; if (o_vld[0] !== 1'b1 || o_data[0] !== W'(i)) begin bad++; $display("FAIL drain_data vld=%b got=%0d exp=%0d", o_vld[0], o_data[0], i); end
      step();
    end
    #1;
    total++; if (o_vld[0] !== 1'b0 || o_lvl[0] !== '0) begin bad++; $display("FAIL drain_empty vld=%b lvl=%0d exp vld=0 lvl=0", o_vld[0], o_lvl[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    vld_in = 1'b1; rdy_out = 1'b1; last_in = 1'b0; data_in = '0;
    step();
    for (int k = 1; k <= 20; k++) begin
      data_in = W'(k);
      #1;
      total++; if (o_vld[0] !== 1'b1 || o_data[0] !== W'(k - 1) || o_rdy[0] !== 1'b1)
        begin bad++; $display("FAIL wrap_beat k=%0d vld=%b rdy=%b got=%0d exp=%0d", k, o_vld[0], o_rdy[0], o_data[0], k - 1); end
      step();
      total++; if (o_lvl[0] !== LW'(1)) begin bad++; $display("FAIL wrap_level k=%0d got=%0d exp=1", k, o_lvl[0]); end
    end
    vld_in = 1'b0; rdy_out = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    vld_in = 1'b1; rdy_out = 1'b0; last_in = 1'b0;
    for (int i = 0; i < D; i++) begin data_in = W'(10 + i); step(); end
    data_in = W'(99); rdy_out = 1'b1;
    #1;
    total++; if (o_rdy[0] !== 1'b0 || o_data[0] !== W'(10)) begin bad++; $display("FAIL fullpop_pre rdy=%b data=%0d exp rdy=0 data=10", o_rdy[0], o_data[0]); end
    step();
    total++; if (o_lvl[0] !== LW'(5)) begin bad++; $display("FAIL fullpop_level got=%0d exp=5", o_lvl[0]); end
    rdy_out = 1'b0;
    #1;
    total++; if (o_rdy[0] !== 1'b1) begin bad++; $display("FAIL fullpop_retry_rdy got=%b exp=1", o_rdy[0]); end
    step();
    total++; if (o_lvl[0] !== LW'(6)) begin bad++; $display("FAIL fullpop_refill got=%0d exp=6", o_lvl[0]); end
    vld_in = 1'b0; rdy_out = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #1;
    total++; if (o_data[0] !== W'(99)) begin bad++; $display("FAIL fullpop_tail got=%0d exp=99", o_data[0]); end
    rdy_out = 1'b0;
  endtask

  task automatic test_packet();
    do_reset();
    vld_in = 1'b1; rdy_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = W'(16'h40 + i); last_in = (i == 2);
      #1;
      total++; if (o_vld[1] !== 1'b0) begin bad++; $display("FAIL pkt_early_vld beat=%0d got=%b exp=0", i, o_vld[1]); end
      step();
    end
    vld_in = 1'b0; last_in = 1'b0;
    #1;
    total++; if (o_vld[1] !== 1'b1) begin bad++; $display("FAIL pkt_release got=%b exp=1", o_vld[1]); end
    rdy_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (o_vld[1] !== 1'b1 || o_data[1] !== W'(16'h40 + i) || o_last[1] !== (i == 2))
        begin bad++; $display("FAIL pkt_pop i=%0d vld=%b data=%h last=%b exp data=%h last=%b", i, o_vld[1], o_data[1], o_last[1], 16'h40 + i, (i == 2)); end
      step();
    end
    rdy_out = 1'b0;
  endtask

  task automatic test_oversize();
    do_reset();
    vld_in = 1'b1; rdy_out = 1'b0; last_in = 1'b0;
    for (int i = 0; i < D; i++) begin data_in = W'(16'h80 + i); step(); end
    vld_in = 1'b0;
    #1;
    total++; if (o_vld[1] !== 1'b1 || o_lvl[1] !== LW'(6) || o_rdy[1] !== 1'b0)
      begin bad++; $display("FAIL oversize_full vld=%b lvl=%0d rdy=%b exp 1/6/0", o_vld[1], o_lvl[1], o_rdy[1]); end
    rdy_out = 1'b1;
    step();
    rdy_out = 1'b0;
    #1;
    total++; if (o_rdy[1] !== 1'b1 || o_lvl[1] !== LW'(5) || o_vld[1] !== 1'b0)
      begin bad++; $display("FAIL oversize_pop rdy=%b lvl=%0d vld=%b exp 1/5/0", o_rdy[1], o_lvl[1], o_vld[1]); end
  endtask

  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      vld_in = 1'b1; rdy_out = 1'b0; last_in = 1'b1;
      for (int i = 0; i < 4; i++) begin data_in = W'(16'h20 + i); step(); end
      data_in = W'(16'h55); rdy_out = 1'b1;
      if (pass == 0) flush = 1'b1; else rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
        total++; if (o_rdy[m] !== 1'b0 || o_vld[m] !== 1'b0)
          begin bad++; $display("FAIL clear_handshake pass=%0d m=%0d rdy=%b vld=%b exp 0/0", pass, m, o_rdy[m], o_vld[m]); end
      end
      step();
      flush = 1'b0; rst_n = 1'b1; vld_in = 1'b0; rdy_out = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
        total++; if (o_lvl[m] !== '0 || o_vld[m] !== 1'b0 || o_data[m] !== '0)
          begin bad++; $display("FAIL clear_after pass=%0d m=%0d lvl=%0d vld=%b data=%h exp 0/0/0", pass, m, o_lvl[m], o_vld[m], o_data[m]); end
      end
    end
    last_in = 1'b0;
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    thr = 2;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) thr = $urandom_range(0, 4);
      vld_in  = ($urandom_range(0, 3) != 0);
      rdy_out = ($urandom_range(0, 3) < thr);
      last_in = ($urandom_range(0, 3) == 0);
      data_in = W'($urandom);
      flush   = ($urandom_range(0, 39) == 0);
      rst_n   = ($urandom_range(0, 79) != 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        total++; if (o_lvl[m] !== LW'(mcnt[m])) begin bad++; $display("FAIL rnd_level c=%0d m=%0d got=%0d exp=%0d", c, m, o_lvl[m], mcnt[m]); end
        total++; if (o_vld[m] !== m_vld(m))     begin bad++; $display("FAIL rnd_vld c=%0d m=%0d got=%b exp=%b", c, m, o_vld[m], m_vld(m)); end
        total++; if (o_rdy[m] !== m_rdy(m))     begin bad++; $display("FAIL rnd_rdy c=%0d m=%0d got=%b exp=%b", c, m, o_rdy[m], m_rdy(m)); end
        total++; if (o_data[m] !== m_data(m))   begin bad++; $display("FAIL rnd_data c=%0d m=%0d got=%h exp=%h", c, m, o_data[m], m_data(m)); end
        total++; if (o_last[m] !== m_last(m))   begin bad++; $display("FAIL rnd_last c=%0d m=%0d got=%b exp=%b", c, m, o_last[m], m_last(m)); end
        total++; if (o_af[m] !== (mcnt[m] >= AF)) begin bad++; $display("FAIL rnd_afull c=%0d m=%0d got=%b lvl=%0d", c, m, o_af[m], mcnt[m]); end
        total++; if (o_ae[m] !== (mcnt[m] <= AE)) begin bad++; $display("FAIL rnd_aempty c=%0d m=%0d got=%b lvl=%0d", c, m, o_ae[m], mcnt[m]); end
      end
      step();
    end
    flush = 1'b0; rst_n = 1'b1; vld_in = 1'b0; rdy_out = 1'b0;
  endtask

  initial begin
    mcnt[0] = 0; mcnt[1] = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_packet();
    test_oversize();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
